// File: rtl/led_chaser_ctrl.sv
// Prescaled LED position sequencer: hold / chase-left / chase-right / bounce,
// with direct position load and active-low one-hot LED decode.
module led_chaser_ctrl #(
  parameter int unsigned DIV_W = 4,
  parameter int unsigned DIV   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] switch,
  output logic [2:0] sel,
  output logic [7:0] led,
  output logic       tick,
  output logic       wrap
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       led_q, led_d;
  logic             dir_up_q, dir_up_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    dir_up_d = dir_up_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    step     = 1'b0;

    if (load) begin
      sel_d    = switch;
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == DIV_W'(DIV)) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (step) begin
      tick_d = 1'b1;
      case (mode)
        MODE_HOLD: sel_d = sel_q;
        MODE_LEFT: begin
          sel_d  = sel_q + 3'd1;
          wrap_d = (sel_q == 3'd7);
        end
        MODE_RIGHT: begin
          sel_d  = sel_q - 3'd1;
          wrap_d = (sel_q == 3'd0);
        end
        MODE_BOUNCE: begin
          // Reversal at an end reflects off it rather than dwelling there.
          if (dir_up_q) begin
            if (sel_q == 3'd7) begin
              sel_d    = 3'd6;
              dir_up_d = 1'b0;
              wrap_d   = 1'b1;
            end else begin
              sel_d = sel_q + 3'd1;
            end
          end else begin
            if (sel_q == 3'd0) begin
              sel_d    = 3'd1;
              dir_up_d = 1'b1;
              wrap_d   = 1'b1;
            end else begin
              sel_d = sel_q - 3'd1;
            end
          end
        end
        default: sel_d = sel_q;
      endcase
    end

    // Decoded from the next position so led stays aligned with sel.
    led_d = ~(8'h01 << sel_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      led_q    <= 8'hFE;
      dir_up_q <= 1'b1;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      led_q    <= led_d;
      dir_up_q <= dir_up_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign sel  = sel_q;
  assign led  = led_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
